// File: rtl/uart_rx_word_packer.sv
// Packs BYTES_PER_WORD received bytes (little-endian) into words and queues them in a show-ahead FIFO.
// Define UART_RX_WORD_PACKER_TIMEOUT_EN to build the inter-byte timeout that discards stale partial words.
module uart_rx_word_packer #(
   parameter int DATA_WIDTH      = 8,
   parameter int BYTES_PER_WORD  = 4,
   parameter int WORD_WIDTH      = DATA_WIDTH * BYTES_PER_WORD,
   parameter int FIFO_ADDR_WIDTH = 2,
   parameter int TIMEOUT_CYCLES  = 104160,
   parameter int TIMEOUT_WIDTH   = 17
) (
   input  logic                       clk_in,
   input  logic                       rst_n_in,
   input  logic [DATA_WIDTH-1:0]      byte_in,
   input  logic                       byte_done_in,
   output logic [WORD_WIDTH-1:0]      word_out,
   output logic                       word_valid_out,
   input  logic                       word_ready_in,
   output logic [FIFO_ADDR_WIDTH:0]   level_out,
   output logic                       overflow_out,
   output logic                       timeout_out,
   input  logic                       clear_flags_in
);
   localparam int CNT_W = $clog2(BYTES_PER_WORD);
   localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BYTES_PER_WORD - 1);

   typedef enum logic {IDLE, ASSEMBLE} state_t;

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [WORD_WIDTH-1:0]    asm_q, asm_d, merged;
   logic                     done_d, strobe, push, pop, full, wr_en;
   logic [FIFO_ADDR_WIDTH:0] wr_ptr, rd_ptr;
   logic [WORD_WIDTH-1:0]    mem [DEPTH];
   logic                     overflow_q;

   // done_d resets high so a level already high at reset release is not a byte.
   assign strobe = byte_done_in & ~done_d;

`ifdef UART_RX_WORD_PACKER_TIMEOUT_EN
   localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
   logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q;
   logic                     tmo_fire, timeout_q;

   // A strobe in the expiry cycle wins over the timeout.
   assign tmo_fire = (state_q == ASSEMBLE) && !strobe && (tmo_cnt_q == TMO_LAST);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (strobe || state_q == IDLE || tmo_fire) tmo_cnt_q <= '0;
         else                                        tmo_cnt_q <= tmo_cnt_q + TIMEOUT_WIDTH'(1);
         if (tmo_fire)            timeout_q <= 1'b1;
         else if (clear_flags_in) timeout_q <= 1'b0;
      end
   end

   assign timeout_out = timeout_q;
`else
   assign timeout_out = 1'b0;
`endif

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      merged = asm_q;
      for (int i = 0; i < BYTES_PER_WORD; i++)
         if (cnt_q == CNT_W'(i)) merged[i*DATA_WIDTH +: DATA_WIDTH] = byte_in;
      state_d = state_q;
      cnt_d   = cnt_q;
      asm_d   = asm_q;
      push    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (strobe) begin
               asm_d   = merged;
               cnt_d   = CNT_W'(1);
               state_d = ASSEMBLE;
            end
         end
         ASSEMBLE: begin
            if (strobe) begin
               asm_d = merged;
               if (cnt_q == LAST_LANE) begin
                  push    = 1'b1;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
`ifdef UART_RX_WORD_PACKER_TIMEOUT_EN
            else if (tmo_fire) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         asm_q   <= '0;
         done_d  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         done_d  <= byte_done_in;
      end
   end

   assign word_valid_out = (wr_ptr != rd_ptr);
   assign full  = (wr_ptr[FIFO_ADDR_WIDTH] != rd_ptr[FIFO_ADDR_WIDTH]) &&
                  (wr_ptr[FIFO_ADDR_WIDTH-1:0] == rd_ptr[FIFO_ADDR_WIDTH-1:0]);
   assign pop   = word_valid_out && word_ready_in;
   assign wr_en = push && (!full || pop);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (FIFO_ADDR_WIDTH+1)'(1);
         if (pop)   rd_ptr <= rd_ptr + (FIFO_ADDR_WIDTH+1)'(1);
         if (push && full && !pop) overflow_q <= 1'b1;
         else if (clear_flags_in)  overflow_q <= 1'b0;
      end
   end

   // NOTE: the storage array has no reset; its contents only matter once valid is high.
   always_ff @(posedge clk_in) begin
      if (wr_en) mem[wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= merged;
   end

   assign word_out     = mem[rd_ptr[FIFO_ADDR_WIDTH-1:0]];
   assign level_out    = wr_ptr - rd_ptr;
   assign overflow_out = overflow_q;
endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Bench for uart_rx_word_packer: queue-based reference model compared every cycle, directed and random stimulus.
module tb_uart_rx_word_packer;
   localparam int DW = 8, BPW = 4, WW = 32, AW = 2, DEPTH = 4, TMO_CYC = 50;

   logic          clk_in = 1'b0, rst_n_in = 1'b0;
   logic [DW-1:0] byte_in = '0;
   logic          byte_done_in = 1'b0, word_ready_in = 1'b0, clear_flags_in = 1'b0;
   logic [WW-1:0] word_out;
   logic          word_valid_out, overflow_out, timeout_out;
   logic [AW:0]   level_out;

   uart_rx_word_packer #(
      .DATA_WIDTH(DW), .BYTES_PER_WORD(BPW), .WORD_WIDTH(WW), .FIFO_ADDR_WIDTH(AW),
      .TIMEOUT_CYCLES(TMO_CYC), .TIMEOUT_WIDTH(17)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .byte_in(byte_in), .byte_done_in(byte_done_in),
      .word_out(word_out), .word_valid_out(word_valid_out), .word_ready_in(word_ready_in),
      .level_out(level_out), .overflow_out(overflow_out), .timeout_out(timeout_out),
      .clear_flags_in(clear_flags_in)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0, n_fail = 0;
   bit cmp_en = 0, rand_ctl = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: bytes gathered in a queue, words in a queue, flags as plain bits.
   logic [DW-1:0] pend[$];
   logic [WW-1:0] fifo_q[$];
   bit m_prev = 1, m_ovf = 0, m_tmo = 0;
`ifdef UART_RX_WORD_PACKER_TIMEOUT_EN
   int m_gap = 0;
`endif

   always @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         pend.delete(); fifo_q.delete();
         m_prev = 1; m_ovf = 0; m_tmo = 0;
`ifdef UART_RX_WORD_PACKER_TIMEOUT_EN
         m_gap = 0;
`endif
      end else begin
         bit strobe, pop, push, full, set_o, set_t;
         logic [WW-1:0] w;
         strobe = byte_done_in && !m_prev;
         m_prev = byte_done_in;
         pop  = (fifo_q.size() > 0) && word_ready_in;
         full = (fifo_q.size() == DEPTH);
         push = 0; set_o = 0; set_t = 0; w = '0;
         if (strobe) begin
            pend.push_back(byte_in);
`ifdef UART_RX_WORD_PACKER_TIMEOUT_EN
            m_gap = 0;
`endif
            if (pend.size() == BPW) begin
               for (int i = 0; i < BPW; i++) w[i*DW +: DW] = pend[i];
               pend.delete();
               push = 1;
            end
         end
`ifdef UART_RX_WORD_PACKER_TIMEOUT_EN
         else if (pend.size() > 0) begin
            m_gap++;
            if (m_gap == TMO_CYC) begin pend.delete(); m_gap = 0; set_t = 1; end
         end
`endif
         if (pop) void'(fifo_q.pop_front());
         if (push) begin
            if (!full || pop) fifo_q.push_back(w);
            else set_o = 1;
         end
         m_ovf = set_o ? 1'b1 : (clear_flags_in ? 1'b0 : m_ovf);
         m_tmo = set_t ? 1'b1 : (clear_flags_in ? 1'b0 : m_tmo);
      end
   end

   always @(posedge clk_in) begin
      #1;
      if (rst_n_in && cmp_en) begin
         check("valid", 32'(word_valid_out), 32'(fifo_q.size() > 0));
         check("level", 32'(level_out), 32'(fifo_q.size()));
         if (fifo_q.size() > 0) check("word", word_out, fifo_q[0]);
         check("overflow", 32'(overflow_out), 32'(m_ovf));
         check("timeout", 32'(timeout_out), 32'(m_tmo));
      end
   end

   task automatic tick();
      @(negedge clk_in);
      if (rand_ctl) begin
         word_ready_in  = 1'($urandom_range(0, 1));
         clear_flags_in = ($urandom_range(0, 15) == 0);
      end
   endtask

   task automatic send_byte(input logic [DW-1:0] b);
      byte_in = b; byte_done_in = 1'b1; tick();
      byte_done_in = 1'b0; tick();
   endtask

   task automatic drain();
      word_ready_in = 1'b1; repeat (6) tick(); word_ready_in = 1'b0;
   endtask

   initial begin
      logic [WW-1:0] exp_w;
      repeat (3) @(negedge clk_in);
      check("reset_valid", 32'(word_valid_out), 0);
      check("reset_level", 32'(level_out), 0);
      check("reset_overflow", 32'(overflow_out), 0);
      check("reset_timeout", 32'(timeout_out), 0);
      rst_n_in = 1'b1; cmp_en = 1; tick();

      // Single word, ready high: valid exactly one clock after the last strobe, then popped.
      word_ready_in = 1'b1;
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      byte_in = 8'h44; byte_done_in = 1'b1;
      check("pre_last_valid", 32'(word_valid_out), 0);
      @(posedge clk_in); #1;
      check("lat_valid", 32'(word_valid_out), 1);
      check("lat_word", word_out, 32'h44332211);
      byte_done_in = 1'b0;
      tick(); tick();
      check("popped_level", 32'(level_out), 0);
      word_ready_in = 1'b0;

      // Five words into a four-deep FIFO: fifth dropped, overflow set.
      for (int k = 0; k < 20; k++) send_byte(8'(k + 1));
      check("full_level", 32'(level_out), 4);
      check("ovf_set", 32'(overflow_out), 1);
      for (int i = 0; i < 4; i++) begin
         exp_w = {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)};
         check("drain_word", word_out, exp_w);
         word_ready_in = 1'b1; tick(); word_ready_in = 1'b0;
      end
      check("drained_valid", 32'(word_valid_out), 0);
      clear_flags_in = 1'b1; tick(); clear_flags_in = 1'b0;
      check("ovf_cleared", 32'(overflow_out), 0);

      // Full FIFO with push and pop in the same cycle.
      for (int k = 0; k < 19; k++) send_byte(8'(8'h30 + k));
      byte_in = 8'hC4; byte_done_in = 1'b1; word_ready_in = 1'b1; tick();
      byte_done_in = 1'b0; word_ready_in = 1'b0; tick();
      check("pushpop_level", 32'(level_out), 4);
      check("pushpop_ovf", 32'(overflow_out), 0);
      check("pushpop_head", word_out, 32'h37363534);
      drain();

      // Stale partial word followed by a long idle gap.
      send_byte(8'h55); send_byte(8'h66);
      repeat (60) tick();
      send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
`ifdef UART_RX_WORD_PACKER_TIMEOUT_EN
      check("tmo_flag", 32'(timeout_out), 1);
      check("tmo_word", word_out, 32'hA3A2A1A0);
`else
      check("tmo_flag", 32'(timeout_out), 0);
      check("stale_word", word_out, 32'hA1A06655);
`endif
      drain();

      // done level held high through reset release is not a byte.
      rst_n_in = 1'b0; byte_in = 8'hEE; byte_done_in = 1'b1; tick(); tick();
      rst_n_in = 1'b1; repeat (3) tick();
      byte_done_in = 1'b0; tick();
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      check("held_level", 32'(level_out), 1);
      check("held_word", word_out, 32'h04030201);
      drain();

      // Asynchronous reset with two words queued and a partial word pending.
      for (int k = 0; k < 10; k++) send_byte(8'(8'h70 + k));
      check("pre_rst_level", 32'(level_out), 2);
      @(posedge clk_in); #3; rst_n_in = 1'b0; #1;
      check("arst_valid", 32'(word_valid_out), 0);
      check("arst_level", 32'(level_out), 0);
      check("arst_ovf", 32'(overflow_out), 0);
      check("arst_tmo", 32'(timeout_out), 0);
      @(negedge clk_in); rst_n_in = 1'b1; tick();
      send_byte(8'h90); send_byte(8'h91); send_byte(8'h92); send_byte(8'h93);
      check("clean_word", word_out, 32'h93929190);
      check("clean_level", 32'(level_out), 1);
      drain();

      // Random bytes, gaps, held done levels, ready and flag clears.
      rand_ctl = 1;
      for (int n = 0; n < 300; n++) begin
         byte_in = 8'($urandom);
         byte_done_in = 1'b1;
         repeat (($urandom_range(0, 3) == 0) ? 3 : 1) tick();
         byte_done_in = 1'b0;
         repeat ($urandom_range(1, 3)) tick();
      end
      rand_ctl = 0; clear_flags_in = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx_word_packer.md
# uart_rx_word_packer

Downstream companion of the UART receiver. Consumes the receiver's parallel byte plus its done level, packs `BYTES_PER_WORD` consecutive bytes little-endian into one word, and buffers completed words in a small show-ahead FIFO. The FIFO is read by the core through a valid/ready handshake. An optional inter-byte timeout discards stale partial words.

## Interface
- `DATA_WIDTH`, 8, byte width; must match the receiver.
- `BYTES_PER_WORD`, 4, bytes per packed word, ≥2.
- `WORD_WIDTH`, 32, equals `DATA_WIDTH*BYTES_PER_WORD`.
- `FIFO_ADDR_WIDTH`, 2, FIFO depth is `2**FIFO_ADDR_WIDTH` words.
- `TIMEOUT_CYCLES`, 104160, maximum clk_in cycles allowed between bytes of one word.
- `TIMEOUT_WIDTH`, 17, width of the timeout counter.

Ports:
- `clk_in`  in  1  system clock.
- `rst_n_in`  in  1  reset, asynchronous, active-low.
- `byte_in`  in  DATA_WIDTH  received byte; valid when byte_done_in is high.
- `byte_done_in`  in  1  receiver done level; each rising edge delivers one byte.
- `word_out`  out  WORD_WIDTH  FIFO head word (show-ahead).
- `word_valid_out`  out  1  FIFO not empty.
- `word_ready_in`  in  1  consumer accepts the head word when high together with word_valid_out.
- `level_out`  out  FIFO_ADDR_WIDTH+1  number of words stored.
- `overflow_out`  out  1  sticky: a completed word was dropped because the FIFO was full.
- `timeout_out`  out  1  sticky: a partial word was discarded; constant 0 when the timeout feature is compiled out.
- `clear_flags_in`  in  1  synchronous clear of the sticky flags.

## Operation
- Byte strobe = `byte_done_in & ~done_d`. `done_d` is a register of byte_done_in with reset value 1, so a level that is already high at reset release is not taken as a byte.
- FSM `IDLE` → `ASSEMBLE` on the first strobe. `byte_in` goes to lane 0 (bits [7:0]). Byte count becomes 1.
- `ASSEMBLE`: each strobe writes `byte_in` to lane `byte_cnt` and increments the count.
  - The strobe that fills lane `BYTES_PER_WORD-1` also pushes the complete word and returns to `IDLE` with count 0.
  - The FIFO write data is the assembled word with the current byte merged in.
- Push when FIFO is full and no pop occurs in the same cycle: the word is dropped and `overflow_out` is set. FIFO contents and pointers are unchanged.
- Push when full with a simultaneous pop: both happen. Level stays at full and no overflow is flagged.
- Pop: `word_valid_out && word_ready_in` advances the read pointer.
- Push into an empty FIFO with ready high: the word is presented next cycle. There is no bypass.
- Pointers are FIFO_ADDR_WIDTH+1 bits and wrap naturally.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the low bits are equal.
  - `level_out` = wr_ptr − rd_ptr, modulo 2^(FIFO_ADDR_WIDTH+1).
- Sticky flags:
  - `clear_flags_in` clears both flags.
  - If a set event and a clear occur in the same cycle, set wins.
- Reset values:
  - FSM `IDLE`, byte count 0, pointers 0, assembly register 0, `done_d`=1.
  - Outputs: `word_valid_out`=0, `level_out`=0, `overflow_out`=0, `timeout_out`=0.
  - `word_out` = memory[0]. The memory is not reset, so the value is don't-care while valid is low.
- Reset mid-word discards the partial word and all FIFO contents.

## Timing
- Strobe at edge k, for the final byte: the word is written at edge k. `word_valid_out` is high after edge k, so latency is 1 clock from sampling the last done rising edge.
- The strobe needs one low sample of byte_done_in between bytes. A level held high across several bytes delivers only one byte.
- A pop at edge k: the next head word is visible after edge k.
- Timeout counter, when enabled:
  - Cleared on every strobe and held at 0 in `IDLE`.
  - Increments each cycle in `ASSEMBLE`.
  - When the counter reaches `TIMEOUT_CYCLES-1` with no strobe in that cycle: the FSM goes to `IDLE`, the count is set to 0, the partial word is discarded and `timeout_out` is set.
  - A strobe in that same cycle wins: the byte is accepted and no timeout occurs.

## Configuration
- `UART_RX_WORD_PACKER_TIMEOUT_EN` defined: the timeout counter and FSM exit are built as described in Timing.
- Macro undefined:
  - The counter is not generated and `timeout_out` is tied to 0.
  - A partial word waits indefinitely; only reset discards it.

## Test plan
- Send 4 strobes with bytes 0x11, 0x22, 0x33, 0x44, ready=1 → one word 0x44332211 with valid high exactly 1 cycle after the 4th strobe, then level_out=0.
- Ready=0, send 20 bytes (5 words) → level 4, then overflow_out=1; draining yields words 1–4 in order and the 5th is absent.
- With FIFO full, hold ready=1 while the 4th byte of a new word strobes → push and pop in the same cycle, level stays 4, overflow_out remains 0.
- Timeout build, TIMEOUT_CYCLES=50: send 2 bytes, idle 60 cycles, then send 0xA0, 0xA1, 0xA2, 0xA3 → timeout_out=1 and the output word is 0xA3A2A1A0. Non-timeout build: the same stimulus yields 0xA1A0xxyy (the first two stale bytes in the low lanes).
- Hold byte_done_in high through reset release, then drop it and pulse it once → exactly one byte counted, not two.
- Assert rst_n_in asynchronously mid-word and with 2 words queued → valid, level and flags are 0 immediately. The next 4 bytes form a clean word.
